ps2_scancode_receiver: RTL and testbench

Receives raw PS/2 keyboard clock/data lines, deserialises 11-bit device-to-host frames, and folds the E0/F0/E1 prefix bytes into single key events. Sits directly upstream of the scancode-to-matrix translator, the pressed-key status tracker and the special-function decoder, all of which consume its `scan_received`/`scancode`/`extended`/`released` outputs on the same clock. Receive-only: it never drives the PS/2 lines.

---
 rtl/ps2_scancode_receiver.sv | 192 +++++++++++++++++++
 tb/tb_ps2_scancode_receiver.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_receiver.sv
// ps2_scancode_receiver
// Receive-only PS/2 keyboard front end: synchronises and filters the raw
// PS/2 clock, deserialises 11-bit device-to-host frames and folds the
// E0/F0/E1 prefix bytes into single key events.
//
// Output handshake: scan_received and frame_error are single-cycle pulses
// with no back-pressure. scancode/extended/released become valid in the
// cycle scan_received is high and hold until the next event.
module ps2_scancode_receiver #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  output logic       scan_received,
  output logic [7:0] scancode,
  output logic       extended,
  output logic       released,
  output logic       frame_error
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          strobe;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          ext_pend;
  logic          rel_pend;
  logic [2:0]    skip_cnt;

  logic          sample;
  logic          frame_ok;
  logic          ignored;

  // Data is sampled from the synchronised pin; the strobe lands mid-bit.
  assign sample   = data_sync[1];
  // Stop bit high and odd parity over data plus parity bit.
  assign frame_ok = sample && ((^shift_reg) ^ par_bit);

  // Bytes that carry no key information (acks, self-test results, errors).
  always_comb begin
    ignored = 1'b0;
    case (shift_reg)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: ignored = 1'b1;
      default: ignored = 1'b0;
    endcase
  end

  // Two-flop synchronisers for both asynchronous PS/2 pins (idle high).
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2clk};
      data_sync <= {data_sync[0], ps2data};
    end
  end

  // Saturating glitch filter on the PS/2 clock; a falling filtered edge is a bit strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      strobe   <= 1'b0;
    end else begin
      strobe <= 1'b0;
      if (clk_sync[1] != filt_clk) begin
        if (filt_cnt == FW'(FILTER_LEN - 1)) begin
          filt_clk <= clk_sync[1];
          filt_cnt <= '0;
          strobe   <= filt_clk;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  // Frame FSM, inactivity timeout and prefix decoder with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      par_bit       <= 1'b0;
      to_cnt        <= '0;
      ext_pend      <= 1'b0;
      rel_pend      <= 1'b0;
      skip_cnt      <= '0;
      scan_received <= 1'b0;
      scancode      <= '0;
      extended      <= 1'b0;
      released      <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      scan_received <= 1'b0;
      frame_error   <= 1'b0;

      if (strobe) begin
        to_cnt <= '0;
      end else if (state != ST_IDLE) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (state != ST_IDLE && !strobe && to_cnt == TW'(TIMEOUT - 1)) begin
        // Keyboard stopped clocking mid-frame: abandon it.
        state       <= ST_IDLE;
        to_cnt      <= '0;
        frame_error <= 1'b1;
        ext_pend    <= 1'b0;
        rel_pend    <= 1'b0;
        skip_cnt    <= '0;
      end else if (strobe) begin
        case (state)
          ST_IDLE: begin
            if (!sample) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              frame_error <= 1'b1;
              ext_pend    <= 1'b0;
              rel_pend    <= 1'b0;
              skip_cnt    <= '0;
            end
          end
          ST_DATA: begin
            shift_reg <= {sample, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_bit <= sample;
            state   <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (!frame_ok) begin
              frame_error <= 1'b1;
              ext_pend    <= 1'b0;
              rel_pend    <= 1'b0;
              skip_cnt    <= '0;
            end else if (skip_cnt != 3'd0) begin
              skip_cnt <= skip_cnt - 1'b1;
            end else if (shift_reg == 8'hE1) begin
              // Pause: swallow the remaining seven bytes of the sequence.
              skip_cnt <= 3'd7;
              ext_pend <= 1'b0;
              rel_pend <= 1'b0;
            end else if (shift_reg == 8'hE0) begin
              ext_pend <= 1'b1;
            end else if (shift_reg == 8'hF0) begin
              rel_pend <= 1'b1;
            end else if (ignored) begin
              ext_pend <= 1'b0;
              rel_pend <= 1'b0;
            end else begin
              scancode      <= shift_reg;
              extended      <= ext_pend;
              released      <= rel_pend;
              scan_received <= 1'b1;
              ext_pend      <= 1'b0;
              rel_pend      <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Bench for ps2_scancode_receiver: drives PS/2 frames at a realistic bit
// period, predicts key events and frame errors from a byte-level model and
// checks them in a decoupled monitor.
module tb_ps2_scancode_receiver;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;
  localparam int HALF       = 30;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2clk = 1'b1;
  logic       ps2data = 1'b1;
  logic       scan_received;
  logic [7:0] scancode;
  logic       extended;
  logic       released;
  logic       frame_error;

  always #5 clk = ~clk;

  ps2_scancode_receiver #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ps2clk       (ps2clk),
    .ps2data      (ps2data),
    .scan_received(scan_received),
    .scancode     (scancode),
    .extended     (extended),
    .released     (released),
    .frame_error  (frame_error)
  );

  // ---------------- scoreboard state ----------------
  // Entry: {is_error, extended, released, scancode}
  logic [10:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending prefixes and the last reported event.
  bit       m_ext, m_rel;
  int       m_skip;
  bit [7:0] m_code;
  bit       m_last_ext, m_last_rel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic void model_clear();
    m_ext = 1'b0;
    m_rel = 1'b0;
  endfunction

  function automatic void model_error();
    exp_q.push_back({1'b1, 10'h000});
    model_clear();
    m_skip = 0;
  endfunction

  function automatic void model_byte(input bit [7:0] b);
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7;
      model_clear();
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
      model_clear();
    end else begin
      exp_q.push_back({1'b0, m_ext, m_rel, b});
      m_code     = b;
      m_last_ext = m_ext;
      m_last_rel = m_rel;
      model_clear();
    end
  endfunction

  function automatic void model_reset();
    model_clear();
    m_skip     = 0;
    m_code     = 8'h00;
    m_last_ext = 1'b0;
    m_last_rel = 1'b0;
  endfunction

  // ---------------- driver tasks ----------------
  // One PS/2 bit: data changes while the clock is high, then a low phase.
  task automatic send_bit(input bit d, input bit glitch);
    ps2data = d;
    if (glitch) begin
      wait_clks(5);
      ps2clk = 1'b0;
      wait_clks(3);
      ps2clk = 1'b1;
      wait_clks(7);
    end else begin
      wait_clks(HALF / 2);
    end
    ps2clk = 1'b0;
    wait_clks(HALF);
    ps2clk = 1'b1;
    wait_clks(HALF / 2);
  endtask

  task automatic send_frame(input bit [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch);
    bit par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(par, glitch);
    // The event is decoded during the stop bit, so predict it first.
    if (bad_par || bad_stop) model_error();
    else model_byte(b);
    send_bit(~bad_stop, glitch);
    ps2data = 1'b1;
  endtask

  task automatic send_seq(input bit [7:0] b0, input bit [7:0] b1, input bit [7:0] b2);
    send_frame(b0, 1'b0, 1'b0, 1'b0);
    send_frame(b1, 1'b0, 1'b0, 1'b0);
    send_frame(b2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_scan_received"}, scan_received, 0);
    check({tag, "_scancode"}, scancode, 0);
    check({tag, "_extended"}, extended, 0);
    check({tag, "_released"}, released, 0);
    check({tag, "_frame_error"}, frame_error, 0);
  endtask

  // ---------------- monitor ----------------
  logic prev_sr = 1'b0;
  logic prev_fe = 1'b0;

  always @(negedge clk) begin
    logic [10:0] got;
    logic [10:0] exp;
    if (rst) begin
      prev_sr = 1'b0;
      prev_fe = 1'b0;
    end else begin
      if (prev_sr) check("scan_received_width", scan_received, 0);
      if (prev_fe) check("frame_error_width", frame_error, 0);
      if (scan_received || frame_error) begin
        if (scan_received && frame_error) got = 11'h7FF;
        else if (frame_error) got = {1'b1, 10'h000};
        else got = {1'b0, extended, released, scancode};
        if (exp_q.size() == 0) begin
          check("unexpected_event", got, 11'h000);
        end else begin
          exp = exp_q.pop_front();
          check("event", got, exp);
        end
      end
      prev_sr = scan_received;
      prev_fe = frame_error;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int kind;
    bit [7:0] b;
    model_reset();

    rst = 1'b1;
    wait_clks(5);
    check_reset_outputs("reset");
    rst = 1'b0;
    wait_clks(20);

    // Plain make code.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    // Extended release of up-arrow.
    send_seq(8'hE0, 8'hF0, 8'h75);
    // Pause sequence yields nothing, then a normal key.
    send_seq(8'hE1, 8'h14, 8'h77);
    send_seq(8'hE1, 8'hF0, 8'h14);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0);
    // Prefix discarded by a parity error, then a clean release.
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    // Ignored byte clears a pending prefix.
    send_seq(8'hF0, 8'hFA, 8'h2B);

    // Timeout after the start bit and four data bits.
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    model_error();
    wait_clks(TIMEOUT + 100);
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);

    // A lone strobe with data high while idle is a bad start bit.
    model_error();
    send_bit(1'b1, 1'b0);
    wait_clks(20);

    // Short glitches inside a full frame must not add bits.
    send_frame(8'h3A, 1'b0, 1'b0, 1'b1);
    send_seq(8'hE0, 8'h6B, 8'h1D);

    // Randomised mix of good, prefixed and corrupted frames.
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 9);
      b    = 8'($urandom_range(0, 255));
      case (kind)
        6: begin
          send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
          send_frame(b, 1'b0, 1'b0, 1'b0);
        end
        7: begin
          send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
          send_frame(b, 1'b0, 1'b0, 1'b0);
        end
        8: send_frame(b, 1'b1, 1'b0, 1'b0);
        9: send_frame(b, 1'b0, 1'b1, 1'b0);
        default: send_frame(b, 1'b0, 1'b0, ($urandom_range(0, 3) == 0));
      endcase
    end
    // Flush any skip state a random E1 may have left behind.
    model_error();
    send_bit(1'b1, 1'b0);
    send_frame(8'h16, 1'b0, 1'b0, 1'b0);

    // Glitchy partial frame interrupted by reset after bit 5.
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    wait_clks(5);
    rst = 1'b1;
    wait_clks(3);
    check_reset_outputs("midframe_reset");
    model_reset();
    rst = 1'b0;
    wait_clks(20);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);

    // Drain and confirm the last event is still held.
    wait_clks(100);
    check("queue_drained", exp_q.size(), 0);
    check("held_scancode", scancode, m_code);
    check("held_extended", extended, m_last_ext);
    check("held_released", released, m_last_rel);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
